// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - start/busy/done handshake bundle for seq_multiplier
// Ports (modport slave = multiplier side, master = requester side):
//    start, signed_mode, a, b   request and operands, driven by master
//    busy, done, product        status and result, driven by slave
interface seq_multiplier_if #(
   parameter int WIDTH = 4
);
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, signed_mode, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, signed_mode, a, b,
      output busy, done, product
   );
endinterface

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - sequential shift-add multiplier, unsigned or two's complement
// Ports:
//    clk      rising-edge clock
//    rst_n    asynchronous active-low reset
//    bus      seq_multiplier_if.slave: start/signed_mode/a/b in, busy/done/product out
module seq_multiplier #(
   parameter int WIDTH = 4
) (
   input logic               clk,
   input logic               rst_n,
   seq_multiplier_if.slave   bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int PW    = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t              r_state;
   logic [PW-1:0]       r_acc;
   logic [PW-1:0]       r_mcand;
   logic [WIDTH-1:0]    r_mplier;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_neg;
   logic                r_busy;
   logic                r_done;
   logic [PW-1:0]       r_product;

   logic [WIDTH-1:0]    w_a_mag;
   logic [WIDTH-1:0]    w_b_mag;
   logic                w_neg;
   logic [PW-1:0]       w_acc_sum;

   // Magnitudes fit in WIDTH unsigned bits: the most-negative operand
   // negates to 2^(WIDTH-1), which is exactly its own bit pattern.
   always_comb begin
      w_a_mag = bus.a;
      w_b_mag = bus.b;
      w_neg   = 1'b0;
      if (bus.signed_mode) begin
         if (bus.a[WIDTH-1]) w_a_mag = -bus.a;
         if (bus.b[WIDTH-1]) w_b_mag = -bus.b;
         w_neg = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      end
   end

   // Multiplicand is pre-shifted each iteration, so it is always aligned
   // to the multiplier bit currently at r_mplier[0].
   assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_cnt     <= '0;
         r_neg     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_product <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                  r_mplier <= w_b_mag;
                  r_neg    <= w_neg;
                  r_acc    <= '0;
                  r_cnt    <= CNT_W'(WIDTH);
                  r_busy   <= 1'b1;
                  r_state  <= S_RUN;
               end else begin
                  r_state  <= S_IDLE;
               end
            end
            S_RUN: begin
               r_acc    <= w_acc_sum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt - 1'b1;
               if (r_cnt == CNT_W'(1)) begin
                  r_product <= r_neg ? (PW'(0) - w_acc_sum) : w_acc_sum;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_state   <= S_DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.product = r_product;
endmodule
